// File: rtl/strhw_common_types.sv
// Shared Streebog datapath types: 512-bit word and the adder client identifiers.
package strhw_common_types;

    typedef logic [511:0] uint512;

    typedef enum logic {
        CL_N     = 1'b0,
        CL_SIGMA = 1'b1
    } client_e;

endpackage

// File: rtl/strhw_adder512.sv
// Two-stage modulo-2^512 adder: low half plus carry in stage 1, high half in stage 2.
module strhw_adder512
    import strhw_common_types::*;
(
    input  logic   clk_i,
    input  logic   rst_i,
    input  logic   trg_i,
    input  uint512 a_i,
    input  uint512 b_i,
    output uint512 sum_o,
    output logic   ready_o
);

    logic [256:0] w_lo_sum;
    logic [255:0] r_lo;
    logic         r_carry;
    logic [255:0] r_a_hi;
    logic [255:0] r_b_hi;
    logic         r_vld1;
    uint512       r_sum;
    logic         r_ready;

    assign w_lo_sum = {1'b0, a_i[255:0]} + {1'b0, b_i[255:0]};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_vld1  <= 1'b0;
            r_ready <= 1'b0;
        end else begin
            r_vld1  <= trg_i;
            r_ready <= r_vld1;
        end
    end

    // Carry out of bit 511 falls off the 256-bit high-half sum.
    always_ff @(posedge clk_i) begin
        r_lo    <= w_lo_sum[255:0];
        r_carry <= w_lo_sum[256];
        r_a_hi  <= a_i[511:256];
        r_b_hi  <= b_i[511:256];
        r_sum   <= {r_a_hi + r_b_hi + {255'd0, r_carry}, r_lo};
    end

    assign sum_o   = r_sum;
    assign ready_o = r_ready;

endmodule

// File: rtl/strhw_adder512_sched.sv
// Round-robin sharing of one strhw_adder512 between the N and Sigma accumulations.
module strhw_adder512_sched
    import strhw_common_types::*;
#(
    parameter int unsigned ADD_LATENCY = 2,
    parameter int unsigned FIRST_PRIO  = 0
) (
    input  logic   clk_i,
    input  logic   rst_i,
    input  logic   n_req_i,
    input  uint512 n_a_i,
    input  uint512 n_b_i,
    output logic   n_gnt_o,
    output logic   n_done_o,
    output uint512 n_result_o,
    input  logic   s_req_i,
    input  uint512 s_a_i,
    input  uint512 s_b_i,
    output logic   s_gnt_o,
    output logic   s_done_o,
    output uint512 s_result_o,
    output logic   busy_o
);

    localparam client_e FIRST_CL = (FIRST_PRIO == 0) ? CL_N : CL_SIGMA;

    logic [1:0]             r_busy;
    client_e                r_ptr;
    logic [ADD_LATENCY-1:0] r_own_vld;
    client_e                r_own_id [ADD_LATENCY];
    logic                   r_n_done;
    logic                   r_s_done;
    uint512                 r_n_result;
    uint512                 r_s_result;

    logic    w_n_elig;
    logic    w_s_elig;
    logic    w_gnt_any;
    client_e w_gnt_id;
    uint512  w_add_a;
    uint512  w_add_b;
    uint512  w_add_sum;
    logic    w_add_ready;
    logic    w_ret;
    client_e w_ret_id;

    always_comb begin
        w_n_elig  = n_req_i && !r_busy[0] && !rst_i;
        w_s_elig  = s_req_i && !r_busy[1] && !rst_i;
        w_gnt_any = w_n_elig || w_s_elig;
        w_gnt_id  = CL_N;
        if (w_n_elig && w_s_elig) begin
            w_gnt_id = r_ptr;
        end else if (w_s_elig) begin
            w_gnt_id = CL_SIGMA;
        end
        w_add_a = (w_gnt_id == CL_SIGMA) ? s_a_i : n_a_i;
        w_add_b = (w_gnt_id == CL_SIGMA) ? s_b_i : n_b_i;
    end

    assign n_gnt_o = w_gnt_any && (w_gnt_id == CL_N);
    assign s_gnt_o = w_gnt_any && (w_gnt_id == CL_SIGMA);

    strhw_adder512 u_adder (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .trg_i   (w_gnt_any),
        .a_i     (w_add_a),
        .b_i     (w_add_b),
        .sum_o   (w_add_sum),
        .ready_o (w_add_ready)
    );

    // Owner tag travels alongside the operands so results can interleave freely.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_own_vld <= '0;
            for (int unsigned i = 0; i < ADD_LATENCY; i++) begin
                r_own_id[i] <= CL_N;
            end
        end else begin
            r_own_vld[0] <= w_gnt_any;
            r_own_id[0]  <= w_gnt_id;
            for (int unsigned i = 1; i < ADD_LATENCY; i++) begin
                r_own_vld[i] <= r_own_vld[i-1];
                r_own_id[i]  <= r_own_id[i-1];
            end
        end
    end

    assign w_ret    = w_add_ready && r_own_vld[ADD_LATENCY-1];
    assign w_ret_id = r_own_id[ADD_LATENCY-1];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_busy     <= '0;
            r_ptr      <= FIRST_CL;
            r_n_done   <= 1'b0;
            r_s_done   <= 1'b0;
            r_n_result <= '0;
            r_s_result <= '0;
        end else begin
            r_n_done  <= w_ret && (w_ret_id == CL_N);
            r_s_done  <= w_ret && (w_ret_id == CL_SIGMA);
            r_busy[0] <= (r_busy[0] && !(w_ret && (w_ret_id == CL_N))) || n_gnt_o;
            r_busy[1] <= (r_busy[1] && !(w_ret && (w_ret_id == CL_SIGMA))) || s_gnt_o;
            if (w_ret && (w_ret_id == CL_N)) begin
                r_n_result <= w_add_sum;
            end
            if (w_ret && (w_ret_id == CL_SIGMA)) begin
                r_s_result <= w_add_sum;
            end
            if (w_gnt_any) begin
                r_ptr <= (w_gnt_id == CL_N) ? CL_SIGMA : CL_N;
            end
        end
    end

    assign n_done_o   = r_n_done;
    assign s_done_o   = r_s_done;
    assign n_result_o = r_n_result;
    assign s_result_o = r_s_result;
    assign busy_o     = |r_busy;

endmodule

// File: tb/tb_strhw_adder512_sched.sv
// Directed literal cases plus randomized traffic checked against a cycle-scheduled model.
module tb_strhw_adder512_sched;
    import strhw_common_types::*;

    localparam int unsigned LAT   = 2;
    localparam int unsigned FPRIO = 0;

    logic   clk = 1'b0;
    logic   rst_i = 1'b1;
    logic   n_req = 1'b0;
    logic   s_req = 1'b0;
    uint512 n_a = '0, n_b = '0, s_a = '0, s_b = '0;
    logic   n_gnt_o, n_done_o, s_gnt_o, s_done_o, busy_o;
    uint512 n_result_o, s_result_o;

    int     passed = 0;
    int     total  = 0;
    longint cyc    = 0;

    strhw_adder512_sched #(.ADD_LATENCY(LAT), .FIRST_PRIO(FPRIO)) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .n_req_i    (n_req),
        .n_a_i      (n_a),
        .n_b_i      (n_b),
        .n_gnt_o    (n_gnt_o),
        .n_done_o   (n_done_o),
        .n_result_o (n_result_o),
        .s_req_i    (s_req),
        .s_a_i      (s_a),
        .s_b_i      (s_b),
        .s_gnt_o    (s_gnt_o),
        .s_done_o   (s_done_o),
        .s_result_o (s_result_o),
        .busy_o     (busy_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input uint512 act, input uint512 exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s cyc=%0d: got %0h expected %0h", name, cyc, act, exp);
    endtask

    function automatic uint512 rnd512();
        uint512 v;
        for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom;
        case ($urandom_range(0, 7))
            0: v = '1;
            1: v = '0;
            2: v[511:256] = '0;
            3: v[255:0] = '1;
            default: ;
        endcase
        return v;
    endfunction

    // Reference: each grant schedules its sum to appear exactly three cycles later.
    uint512 m_res [2];
    uint512 m_pv  [2];
    longint m_due [2];
    longint m_iss [2];
    int     m_ptr = FPRIO;

    always @(negedge clk) begin
        bit e0, e1, g0, g1, bz0, bz1;
        if (rst_i) begin
            for (int k = 0; k < 2; k++) begin
                m_due[k] = -1;
                m_iss[k] = -1;
                m_res[k] = '0;
                m_pv[k]  = '0;
            end
            m_ptr = FPRIO;
        end else begin
            for (int k = 0; k < 2; k++)
                if (m_due[k] == cyc) m_res[k] = m_pv[k];
            bz0 = (m_iss[0] < cyc) && (cyc < m_due[0]);
            bz1 = (m_iss[1] < cyc) && (cyc < m_due[1]);
            e0 = n_req && !bz0;
            e1 = s_req && !bz1;
            g0 = 1'b0;
            g1 = 1'b0;
            if (e0 && e1) begin
                if (m_ptr == 0) g0 = 1'b1; else g1 = 1'b1;
            end else begin
                g0 = e0;
                g1 = e1;
            end
            chk("m_n_gnt", uint512'(n_gnt_o), uint512'(g0));
            chk("m_s_gnt", uint512'(s_gnt_o), uint512'(g1));
            chk("m_n_done", uint512'(n_done_o), uint512'(m_due[0] == cyc));
            chk("m_s_done", uint512'(s_done_o), uint512'(m_due[1] == cyc));
            chk("m_n_result", n_result_o, m_res[0]);
            chk("m_s_result", s_result_o, m_res[1]);
            chk("m_busy", uint512'(busy_o), uint512'(bz0 || bz1));
            if (g0) begin
                m_iss[0] = cyc; m_due[0] = cyc + 3; m_pv[0] = n_a + n_b; m_ptr = 1;
            end
            if (g1) begin
                m_iss[1] = cyc; m_due[1] = cyc + 3; m_pv[1] = s_a + s_b; m_ptr = 0;
            end
        end
    end

    // Adder results must always have a tracked owner.
    always @(negedge clk) begin
        if (!rst_i && dut.w_add_ready)
            chk("owner_valid", uint512'(dut.r_own_vld[LAT-1]), uint512'(1));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_single(input bit cl, input uint512 a, input uint512 b,
                                input uint512 exp, input string tag);
        longint t;
        bit got, other;
        if (cl) begin s_req = 1'b1; s_a = a; s_b = b; end
        else    begin n_req = 1'b1; n_a = a; n_b = b; end
        @(negedge clk);
        chk({tag, "_gnt"}, uint512'(cl ? s_gnt_o : n_gnt_o), uint512'(1));
        t = cyc;
        tick();
        n_req = 1'b0;
        s_req = 1'b0;
        got = 1'b0;
        other = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin
            @(negedge clk);
            if (cl ? n_done_o : s_done_o) other = 1'b1;
            if (cl ? s_done_o : n_done_o) begin
                got = 1'b1;
                chk({tag, "_lat"}, uint512'(cyc - t), uint512'(3));
                chk({tag, "_res"}, cl ? s_result_o : n_result_o, exp);
            end
        end
        chk({tag, "_done_seen"}, uint512'(got), uint512'(1));
        chk({tag, "_other_quiet"}, uint512'(other), uint512'(0));
        tick();
    endtask

    task automatic contend(input bit n_first, input string tag);
        longint t, nd, sd;
        n_req = 1'b1; n_a = rnd512(); n_b = rnd512();
        s_req = 1'b1; s_a = rnd512(); s_b = rnd512();
        @(negedge clk);
        t = cyc;
        chk({tag, "_first_n"}, uint512'(n_gnt_o), uint512'(n_first));
        chk({tag, "_first_s"}, uint512'(s_gnt_o), uint512'(!n_first));
        tick();
        if (n_first) n_req = 1'b0; else s_req = 1'b0;
        @(negedge clk);
        chk({tag, "_second"}, uint512'(n_first ? s_gnt_o : n_gnt_o), uint512'(1));
        tick();
        n_req = 1'b0;
        s_req = 1'b0;
        nd = -1;
        sd = -1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (n_done_o && nd < 0) nd = cyc - t;
            if (s_done_o && sd < 0) sd = cyc - t;
        end
        chk({tag, "_n_done_at"}, uint512'(nd), uint512'(n_first ? 3 : 4));
        chk({tag, "_s_done_at"}, uint512'(sd), uint512'(n_first ? 4 : 3));
        tick();
    endtask

    initial begin
        int k, nd;
        longint gc [3];
        uint512 dv [3];
        bit g0, g1, flag;

        repeat (3) @(posedge clk);
        #1 rst_i = 1'b0;

        chk("reset_busy", uint512'(busy_o), uint512'(0));
        chk("reset_n_result", n_result_o, '0);

        issue_single(1'b0, '0, 512'd512, 512'd512, "basic_n");
        issue_single(1'b1, {256'd0, {256{1'b1}}}, 512'd1, {255'd0, 1'b1, 256'd0}, "cross_half");
        issue_single(1'b1, '1, 512'd2, 512'd1, "wrap");

        contend(1'b1, "cont1");
        issue_single(1'b0, 512'd3, 512'd4, 512'd7, "solo_n");
        contend(1'b0, "cont2");

        // Back-to-back single client: 1+1, 2+2, 3+3.
        n_req = 1'b1; n_a = 512'd1; n_b = 512'd1;
        k = 0;
        nd = 0;
        for (int i = 0; i < 20 && (k < 3 || nd < 3); i++) begin
            @(negedge clk);
            g0 = n_gnt_o;
            if (n_done_o && nd < 3) begin dv[nd] = n_result_o; nd++; end
            if (g0 && k < 3) begin gc[k] = cyc; k++; end
            tick();
            if (k == 3) n_req = 1'b0;
            else if (g0) begin n_a = uint512'(k + 1); n_b = uint512'(k + 1); end
        end
        chk("b2b_grants", uint512'(k), uint512'(3));
        chk("b2b_dones", uint512'(nd), uint512'(3));
        chk("b2b_gap1", uint512'(gc[1] - gc[0]), uint512'(3));
        chk("b2b_gap2", uint512'(gc[2] - gc[1]), uint512'(3));
        chk("b2b_r0", dv[0], 512'd2);
        chk("b2b_r1", dv[1], 512'd4);
        chk("b2b_r2", dv[2], 512'd6);

        // Reset one cycle after grant drops the op.
        n_req = 1'b1; n_a = rnd512(); n_b = rnd512();
        @(negedge clk);
        chk("rst_mid_gnt", uint512'(n_gnt_o), uint512'(1));
        tick();
        n_req = 1'b0;
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        flag = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (n_done_o) flag = 1'b1;
        end
        chk("rst_mid_no_done", uint512'(flag), uint512'(0));
        chk("rst_mid_result", n_result_o, '0);
        chk("rst_mid_busy", uint512'(busy_o), uint512'(0));
        tick();
        issue_single(1'b0, 512'd5, 512'd7, 512'd12, "post_rst");

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            g0 = n_gnt_o;
            g1 = s_gnt_o;
            tick();
            rst_i = ($urandom_range(0, 299) == 0);
            if (n_req) begin
                if (g0) begin
                    n_req = $urandom_range(0, 1) == 1;
                    n_a = rnd512(); n_b = rnd512();
                end else if ($urandom_range(0, 15) == 0) n_req = 1'b0;
            end else if ($urandom_range(0, 2) == 0) begin
                n_req = 1'b1; n_a = rnd512(); n_b = rnd512();
            end else begin
                n_a = rnd512();
            end
            if (s_req) begin
                if (g1) begin
                    s_req = $urandom_range(0, 1) == 1;
                    s_a = rnd512(); s_b = rnd512();
                end else if ($urandom_range(0, 15) == 0) s_req = 1'b0;
            end else if ($urandom_range(0, 2) == 0) begin
                s_req = 1'b1; s_a = rnd512(); s_b = rnd512();
            end else begin
                s_b = rnd512();
            end
        end
        rst_i = 1'b0;
        n_req = 1'b0;
        s_req = 1'b0;
        repeat (8) tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d passed so far", passed, total);
        $fatal(1);
    end

endmodule
